// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: sample memory shared by the AXI bridge and the FFT core.
// The bridge loads real samples and later drains complex results. The core
// owns the memory while the transform runs. A LOAD -> CALC -> UNLOAD
// ownership FSM decides who may access the memory and drives the calc
// start/end handshake.
// Optional build macro: BIT_REVERSE_LOAD_EN. When it is defined, bridge
// writes are stored at bit-reversed addresses, so the core reads its input
// in decimation-in-time order.
module fft_sample_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [11:0]             i_SAMPLES_NUMBER,
    input  logic                    i_WRITE_ram,
    input  logic                    i_READ_ram,
    input  logic [ADDR_W-1:0]       i_SAMPLE_INDEX_ram,
    input  logic signed [15:0]      i_SAMPLE_ram,
    input  logic                    i_DATA_LOADED,
    output logic [DATA_WIDTH-1:0]   o_DATA_FROM_RAM,
    input  logic                    i_CORE_WE,
    input  logic                    i_CORE_RE,
    input  logic [ADDR_W-1:0]       i_CORE_ADDR,
    input  logic [DATA_WIDTH-1:0]   i_CORE_WDATA,
    output logic [DATA_WIDTH-1:0]   o_CORE_RDATA,
    input  logic                    i_CORE_DONE,
    output logic                    o_CALC_START,
    output logic                    o_CALC_END,
    output logic                    o_ERR
);

    localparam int              HALF_W  = DATA_WIDTH / 2;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    // Tell whether an index falls inside the physical storage.
    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < DEPTH_L);
    endfunction

    // Build a complex word from a bridge sample. The real half is the
    // sign-extended sample and the imaginary half is zero.
    function automatic logic [DATA_WIDTH-1:0] real_to_word(input logic signed [15:0] s);
        logic signed [HALF_W-1:0] re;
        re = HALF_W'(s);
        return {re, {HALF_W{1'b0}}};
    endfunction

    // Limit the requested sample count to the storage depth.
    function automatic logic [ADDR_W:0] clamp_n(input logic [11:0] n);
        if (32'(n) > 32'(DEPTH)) begin
            return DEPTH_L;
        end
        return (ADDR_W + 1)'(n);
    endfunction

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_W:0]         n_q;
    logic                    calc_start_q;
    logic                    start_d;
    logic                    calc_end;
    logic                    err_q;
    logic                    err_d;
    logic [DATA_WIDTH-1:0]   rdata_p1;
    logic [ADDR_W-1:0]       load_addr;
    logic                    bridge_we;
    logic                    core_we;
    logic                    core_re;
    logic                    terminal;
    logic                    n_too_big;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef BIT_REVERSE_LOAD_EN
    // True when n is a non-zero power of two.
    function automatic logic is_pow2(input logic [11:0] n);
        return (n != 12'd0) && ((n & (n - 12'd1)) == 12'd0);
    endfunction

    // Return the position of the highest set bit, which is log2 when n is a power of two.
    function automatic int log2_floor(input logic [11:0] n);
        int k;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (n[i]) k = i;
        end
        return k;
    endfunction

    // Reverse the low k bits of the index. Higher bits pass through unchanged.
    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] idx, input int k);
        logic [ADDR_W-1:0] r;
        r = idx;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((i < k) && ((k - 1 - i) < ADDR_W)) r[i] = idx[k - 1 - i];
        end
        return r;
    endfunction

    logic n_pow2;
    assign n_pow2    = is_pow2(i_SAMPLES_NUMBER);
    assign load_addr = n_pow2 ? bit_rev(i_SAMPLE_INDEX_ram, log2_floor(i_SAMPLES_NUMBER))
                              : i_SAMPLE_INDEX_ram;
`else
    assign load_addr = i_SAMPLE_INDEX_ram;
`endif

    assign bridge_we = (state_q == ST_LOAD) && i_WRITE_ram && in_range(load_addr);
    assign core_we   = (state_q == ST_CALC) && i_CORE_WE && in_range(i_CORE_ADDR);
    assign core_re   = (state_q == ST_CALC) && i_CORE_RE;
    assign terminal  = (state_q == ST_UNLOAD) && i_READ_ram
                       && ({1'b0, i_SAMPLE_INDEX_ram} == n_q);
    assign n_too_big = (32'(i_SAMPLES_NUMBER) > 32'(DEPTH));

    // Ownership FSM next state, handshake outputs and sticky protocol errors.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        calc_end = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_LOAD: begin
                if (i_DATA_LOADED) begin
                    state_d = ST_CALC;
                    start_d = 1'b1;
                    if (n_too_big) err_d = 1'b1;
                end
            end
            ST_CALC: begin
                if (i_CORE_DONE) state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                calc_end = 1'b1;
                if (terminal) begin
                    state_d  = ST_LOAD;
                    calc_end = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        if (i_WRITE_ram && (state_q != ST_LOAD)) err_d = 1'b1;
        if (i_DATA_LOADED && (state_q != ST_LOAD)) err_d = 1'b1;
        if (i_CORE_DONE && (state_q != ST_CALC)) err_d = 1'b1;
`ifdef BIT_REVERSE_LOAD_EN
        if ((state_q == ST_LOAD) && i_WRITE_ram && !n_pow2) err_d = 1'b1;
`endif
    end

    // Control registers: FSM state, start pulse, error flag and latched frame size.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_LOAD;
            calc_start_q <= 1'b0;
            err_q        <= 1'b0;
            n_q          <= '0;
        end else begin
            state_q      <= state_d;
            calc_start_q <= start_d;
            err_q        <= err_d;
            if ((state_q == ST_LOAD) && i_DATA_LOADED) begin
                n_q <= clamp_n(i_SAMPLES_NUMBER);
            end
        end
    end

    // Single memory write port. The bridge owns it in LOAD and the core owns it in CALC.
    always_ff @(posedge i_clk) begin
        if (bridge_we) begin
            mem[load_addr] <= real_to_word(i_SAMPLE_ram);
        end else if (core_we) begin
            mem[i_CORE_ADDR] <= i_CORE_WDATA;
        end
    end

    // Core read, stage p0 -> p1. A read and a write to the same address in one cycle return the old word.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_p1 <= '0;
        end else if (core_re) begin
            rdata_p1 <= in_range(i_CORE_ADDR) ? mem[i_CORE_ADDR] : '0;
        end
    end

    assign o_DATA_FROM_RAM = ((state_q == ST_UNLOAD) && in_range(i_SAMPLE_INDEX_ram))
                             ? mem[i_SAMPLE_INDEX_ram] : '0;
    assign o_CORE_RDATA    = rdata_p1;
    assign o_CALC_START    = calc_start_q;
    assign o_CALC_END      = calc_end;
    assign o_ERR           = err_q;

endmodule
